cdb_arbiter: RTL

- Writeback-side arbiter for the execution stage: collects result writeback requests from the execution units (ALU, DIV, FPU, FDIV, CSR, MEM) over the active-low req_/ack_ handshake the units drive.
- Grants one unit per cycle with round-robin fairness.
- Registers the granted result and broadcasts it on the common data bus (CDB) to the reorder buffer and reservation stations.
- Forms the receiving end of each unit's wb_req_/wb_ack_ pair.

---
 rtl/cdb_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin writeback arbiter driving the common data bus: combinational grant, CDB registered one cycle later.
// No stall input: every receiver takes every broadcast; flush and reset suppress grants.
module cdb_arbiter #(
   parameter  int UNITS     = 6,
   parameter  int DATA      = 32,
   parameter  int ROB_DEPTH = 32,
   localparam int ROB       = $clog2(ROB_DEPTH),
   localparam int UIDX      = $clog2(UNITS)
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_flush,
   input  logic [UNITS-1:0]      i_wb_req_,
   output logic [UNITS-1:0]      o_wb_ack_,
   input  logic [UNITS*ROB-1:0]  i_wb_rob_id,
   input  logic [UNITS*DATA-1:0] i_wb_data,
   input  logic [UNITS-1:0]      i_wb_exp,
   input  logic [UNITS*4-1:0]    i_wb_exp_code,
   output logic                  o_cdb_valid,
   output logic [UIDX-1:0]       o_cdb_unit,
   output logic [ROB-1:0]        o_cdb_rob_id,
   output logic [DATA-1:0]       o_cdb_data,
   output logic                  o_cdb_exp,
   output logic [3:0]            o_cdb_exp_code
);

   logic [UIDX-1:0]  r_ptr;
   logic             r_cdb_valid;
   logic [UIDX-1:0]  r_cdb_unit;
   logic [ROB-1:0]   r_cdb_rob_id;
   logic [DATA-1:0]  r_cdb_data;
   logic             r_cdb_exp;
   logic [3:0]       r_cdb_exp_code;

   logic             w_found;
   logic             w_grant;
   logic [UIDX-1:0]  w_gnt;
   logic [UIDX-1:0]  w_ptr_nxt;
   logic [UNITS-1:0] w_ack_;
   int               w_idx;

   // Scan ptr, ptr+1, ... with an explicit modulo so non-power-of-two UNITS wraps exactly.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      w_idx   = 0;
      for (int k = 0; k < UNITS; k++) begin
         w_idx = int'(r_ptr) + k;
         if (w_idx >= UNITS) w_idx = w_idx - UNITS;
         if (!w_found && !i_wb_req_[w_idx]) begin
            w_found = 1'b1;
            w_gnt   = UIDX'(w_idx);
         end
      end
   end

   assign w_grant   = w_found & ~i_reset & ~i_flush;
   assign w_ptr_nxt = (w_gnt == UIDX'(UNITS-1)) ? '0 : w_gnt + 1'b1;

   always_comb begin
      w_ack_ = '1;
      if (w_grant) w_ack_[w_gnt] = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ptr          <= '0;
         r_cdb_valid    <= 1'b0;
         r_cdb_unit     <= '0;
         r_cdb_rob_id   <= '0;
         r_cdb_data     <= '0;
         r_cdb_exp      <= 1'b0;
         r_cdb_exp_code <= '0;
      end else begin
         r_cdb_valid <= w_grant;
         if (w_grant) begin
            r_ptr          <= w_ptr_nxt;
            r_cdb_unit     <= w_gnt;
            r_cdb_rob_id   <= i_wb_rob_id[w_gnt*ROB +: ROB];
            r_cdb_data     <= i_wb_data[w_gnt*DATA +: DATA];
            r_cdb_exp      <= i_wb_exp[w_gnt];
            r_cdb_exp_code <= i_wb_exp_code[w_gnt*4 +: 4];
         end
      end
   end

   assign o_wb_ack_      = w_ack_;
   assign o_cdb_valid    = r_cdb_valid;
   assign o_cdb_unit     = r_cdb_unit;
   assign o_cdb_rob_id   = r_cdb_rob_id;
   assign o_cdb_data     = r_cdb_data;
   assign o_cdb_exp      = r_cdb_exp;
   assign o_cdb_exp_code = r_cdb_exp_code;

   // Protocol checks: requests must be known, grant is one-hot-low, pointer stays in range.
   always @(posedge i_clk) begin
      if (!i_reset) begin
         assert (!$isunknown(i_wb_req_));
         assert ($countones(~w_ack_) <= 1);
         assert (int'(r_ptr) < UNITS);
      end
   end

endmodule
